// File: rtl/div_seq_ctrl.sv
// Sequencing controller for the sign-magnitude restoring divider.
// Accepts one operand pair, produces one quotient bit per cycle, then holds the result until it is consumed.
module div_seq_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend_mag,
  input  logic             dividend_sign,
  input  logic [WIDTH-1:0] divisor_mag,
  input  logic             divisor_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient_mag,
  output logic             quotient_sign,
  output logic [WIDTH-1:0] remainder_mag,
  output logic             remainder_sign,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             dd_sign_r;
  logic             dv_sign_r;

  logic             accept;
  logic             last_step;
  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] quo_step;

  assign accept    = in_valid & in_ready;
  assign last_step = (cnt == '0);

  // Trial subtraction on the shifted {R,Q}; bit WIDTH+1 of diff is the borrow.
  assign diff     = {rem, quo[WIDTH-1]} - {2'b00, dvs};
  assign rem_step = diff[WIDTH+1] ? {rem[WIDTH-1:0], quo[WIDTH-1]} : diff[WIDTH:0];
  assign quo_step = {quo[WIDTH-2:0], ~diff[WIDTH+1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) begin
        if (divisor_mag == '0 || dividend_mag == '0) state_next = DONE;
        else                                         state_next = CALC;
      end
      CALC: if (last_step) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == CALC) || (state == DONE);
  end

  // Result fields are only written on a result load, so they survive the handover.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      rem            <= '0;
      quo            <= '0;
      dvs            <= '0;
      dd_sign_r      <= 1'b0;
      dv_sign_r      <= 1'b0;
      quotient_mag   <= '0;
      quotient_sign  <= 1'b0;
      remainder_mag  <= '0;
      remainder_sign <= 1'b0;
      div_by_zero    <= 1'b0;
    end else if (accept) begin
      cnt       <= CW'(WIDTH - 1);
      rem       <= '0;
      quo       <= dividend_mag;
      dvs       <= divisor_mag;
      dd_sign_r <= dividend_sign;
      dv_sign_r <= divisor_sign;
      if (divisor_mag == '0) begin
        quotient_mag   <= '1;
        quotient_sign  <= 1'b1;
        remainder_mag  <= '1;
        remainder_sign <= 1'b1;
        div_by_zero    <= 1'b1;
      end else if (dividend_mag == '0) begin
        quotient_mag   <= '0;
        quotient_sign  <= 1'b0;
        remainder_mag  <= '0;
        remainder_sign <= 1'b0;
        div_by_zero    <= 1'b0;
      end
    end else if (state == CALC) begin
      rem <= rem_step;
      quo <= quo_step;
      if (!last_step) begin
        cnt <= cnt - CW'(1);
      end else begin
        quotient_mag   <= quo_step;
        quotient_sign  <= (dd_sign_r ^ dv_sign_r) & (quo_step != '0);
        remainder_mag  <= rem_step[WIDTH-1:0];
        remainder_sign <= dd_sign_r & (rem_step != '0);
        div_by_zero    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed cases from the divider rules plus
// randomized operand pairs checked against an integer-arithmetic reference.
module tb_div_seq_ctrl;

  localparam int W    = 3;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend_mag;
  logic         dividend_sign;
  logic [W-1:0] divisor_mag;
  logic         divisor_sign;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient_mag;
  logic         quotient_sign;
  logic [W-1:0] remainder_mag;
  logic         remainder_sign;
  logic         div_by_zero;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  div_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend_mag(dividend_mag), .dividend_sign(dividend_sign),
    .divisor_mag(divisor_mag), .divisor_sign(divisor_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient_mag(quotient_mag), .quotient_sign(quotient_sign),
    .remainder_mag(remainder_mag), .remainder_sign(remainder_sign),
    .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer truncating division with the sign and zero rules.
  task automatic refModel(input int a, input int as_, input int b, input int bs,
                          output int q, output int qs, output int r, output int rs,
                          output int dbz, output int lat);
    if (b == 0) begin
      q = MAXV; qs = 1; r = MAXV; rs = 1; dbz = 1; lat = 1;
    end else if (a == 0) begin
      q = 0; qs = 0; r = 0; rs = 0; dbz = 0; lat = 1;
    end else begin
      q   = a / b;
      r   = a % b;
      qs  = (q != 0) ? (as_ ^ bs) : 0;
      rs  = (r != 0) ? as_ : 0;
      dbz = 0;
      lat = W + 1;
    end
  endtask

  task automatic checkResult(input string tag, input int q, input int qs, input int r,
                             input int rs, input int dbz);
    checkOutput({tag, " q_mag"}, quotient_mag, q);
    checkOutput({tag, " q_sign"}, quotient_sign, qs);
    checkOutput({tag, " r_mag"}, remainder_mag, r);
    checkOutput({tag, " r_sign"}, remainder_sign, rs);
    checkOutput({tag, " dbz"}, div_by_zero, dbz);
  endtask

  task automatic applyStimulus(input string tag, input int a, input int as_, input int b,
                               input int bs, input int hold);
    int q, qs, r, rs, dbz, lat, waited, cyc;
    refModel(a, as_, b, bs, q, qs, r, rs, dbz, lat);
    @(negedge clk);
    waited = 0;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, " in_ready_idle"}, in_ready, 1);
    dividend_mag  = W'(a);
    dividend_sign = as_[0];
    divisor_mag   = W'(b);
    divisor_sign  = bs[0];
    in_valid      = 1'b1;
    @(negedge clk);
    in_valid      = 1'b0;
    dividend_mag  = W'($urandom_range(0, MAXV));
    divisor_mag   = W'($urandom_range(0, MAXV));
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, " latency"}, cyc, lat);
    checkResult(tag, q, qs, r, rs, dbz);
    checkOutput({tag, " busy_done"}, busy, 1);
    checkOutput({tag, " in_ready_done"}, in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      in_valid      = 1'b1;
      dividend_mag  = W'($urandom_range(1, MAXV));
      divisor_mag   = W'($urandom_range(1, MAXV));
      @(negedge clk);
      checkOutput({tag, " hold_valid"}, out_valid, 1);
      checkOutput({tag, " hold_in_ready"}, in_ready, 0);
      checkResult({tag, " hold"}, q, qs, r, rs, dbz);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, " valid_cleared"}, out_valid, 0);
    checkOutput({tag, " in_ready_back"}, in_ready, 1);
    checkOutput({tag, " busy_cleared"}, busy, 0);
    checkOutput({tag, " q_retained"}, quotient_mag, q);
  endtask

  initial begin
    int q, qs, r, rs, dbz, lat;
    int ov_at[$];
    int qv[$];
    int rv[$];
    int rdy_gap;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dividend_mag = '0; dividend_sign = 1'b0; divisor_mag = '0; divisor_sign = 1'b0;
    #1;
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset busy", busy, 0);
    checkResult("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("p7/p3", 7, 0, 3, 0, 0);
    applyStimulus("n7/p3", 7, 1, 3, 0, 0);
    applyStimulus("p7/n3", 7, 0, 3, 1, 0);
    applyStimulus("n1/p5", 1, 1, 5, 0, 0);
    applyStimulus("p5/n0", 5, 0, 0, 1, 0);
    applyStimulus("n0/p3", 0, 1, 3, 0, 0);
    applyStimulus("p6/p2 hold", 6, 0, 2, 0, 5);

    // Reset during the second CALC cycle of +7 / +1.
    @(negedge clk);
    dividend_mag = 3'd7; dividend_sign = 1'b0; divisor_mag = 3'd1; divisor_sign = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst in_ready", in_ready, 1);
    checkOutput("midrst out_valid", out_valid, 0);
    checkOutput("midrst busy", busy, 0);
    checkResult("midrst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("p4/p2 after rst", 4, 0, 2, 0, 0);

    // Back-to-back with out_ready tied high; in_valid stays up across the first handover.
    @(negedge clk);
    dividend_mag = 3'd5; dividend_sign = 1'b0; divisor_mag = 3'd5; divisor_sign = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    rdy_gap = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 0) begin
        dividend_mag = 3'd3; divisor_mag = 3'd7;
      end
      if (k == W + 2) in_valid = 1'b0;
      if (k == W + 1) rdy_gap = in_ready;
      if (out_valid) begin
        ov_at.push_back(k);
        qv.push_back(int'(quotient_mag));
        rv.push_back(int'(remainder_mag));
      end
    end
    out_ready = 1'b0;
    refModel(5, 0, 5, 0, q, qs, r, rs, dbz, lat);
    checkOutput("b2b present count", ov_at.size(), 2);
    checkOutput("b2b in_ready between", rdy_gap, 1);
    if (ov_at.size() == 2) begin
      checkOutput("b2b first valid cycle", ov_at[0], lat - 1);
      checkOutput("b2b first q", qv[0], q);
      checkOutput("b2b first r", rv[0], r);
      refModel(3, 0, 7, 0, q, qs, r, rs, dbz, lat);
      checkOutput("b2b second valid cycle", ov_at[1], ov_at[0] + 5);
      checkOutput("b2b second q", qv[1], q);
      checkOutput("b2b second r", rv[1], r);
    end

    for (int t = 0; t < 40; t++) begin
      applyStimulus($sformatf("rand%0d", t),
                    int'($urandom_range(0, MAXV)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, MAXV)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
